// File: rtl/stack_seq_pkg.sv
// Shared op and state encodings for the stack sequencer, plus a byte-count helper.
package stack_seq_pkg;

  typedef enum logic [2:0] {
    OP_PUSH   = 3'b000,
    OP_POP    = 3'b001,
    OP_CALL   = 3'b010,
    OP_RET    = 3'b011,
    OP_LOADSP = 3'b100
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_DEC  = 3'd1,
    S_WR   = 3'd2,
    S_RD   = 3'd3,
    S_INC  = 3'd4,
    S_LOAD = 3'd5,
    S_ERR  = 3'd6
  } state_e;

  // CALL/RET move a two-byte return address; PUSH/POP move a single byte.
  function automatic logic [1:0] op_bytes(input logic [2:0] op);
    if ((op == OP_CALL) || (op == OP_RET)) begin
      return 2'd2;
    end else begin
      return 2'd1;
    end
  endfunction

endpackage

// File: rtl/stack_depth_guard.sv
// Stack depth counter and overflow/underflow guard; active only with STACK_GUARD_EN,
// otherwise depth is tied to 0 and every request is allowed.
module stack_depth_guard
  import stack_seq_pkg::*;
#(
  parameter int DEPTH_W   = 8,
  parameter int DEPTH_MAX = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               inc,
  input  logic               dec,
  input  logic               clr,
  input  logic [2:0]         op,
  output logic [DEPTH_W-1:0] depth,
  output logic               ok
);

`ifdef STACK_GUARD_EN
  logic [DEPTH_W:0] need;
  logic [DEPTH_W:0] room;

  always_comb begin
    need = (DEPTH_W+1)'(op_bytes(op));
    room = (DEPTH_W+1)'(DEPTH_MAX) - {1'b0, depth};
    if ((op == OP_PUSH) || (op == OP_CALL)) begin
      ok = (need <= room);
    end else if ((op == OP_POP) || (op == OP_RET)) begin
      ok = (need <= {1'b0, depth});
    end else begin
      ok = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      depth <= '0;
    end else if (clr) begin
      depth <= '0;
    end else if (inc) begin
      depth <= depth + DEPTH_W'(1);
    end else if (dec) begin
      depth <= depth - DEPTH_W'(1);
    end else begin
      depth <= depth;
    end
  end
`else
  logic unused_guard;
  assign unused_guard = ^{clk, reset, inc, dec, clr, op};
  assign depth        = '0;
  assign ok           = 1'b1;
`endif

endmodule

// File: rtl/stack_sequencer.sv
// Stack pointer / memory strobe sequencer for PUSH, POP, CALL, RET and LOADSP.
// Optional depth guard enabled by defining STACK_GUARD_EN.
module stack_sequencer
  import stack_seq_pkg::*;
#(
  parameter int DEPTH_W   = 8,
  parameter int DEPTH_MAX = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req,
  input  logic [2:0]         op,
  output logic               busy,
  output logic               done,
  output logic               sp_outn,
  output logic               sp_loadn,
  output logic               sp_cupn,
  output logic               sp_cdownn,
  output logic               mem_wen,
  output logic               mem_oen,
  output logic               byte_sel,
  output logic               rd_latch,
  output logic               fault,
  output logic [DEPTH_W-1:0] depth
);

  state_e     state;
  logic [2:0] op_r;
  logic       second;
  logic       last_byte;
  logic       ok;

  assign last_byte = (op_r == OP_PUSH) || (op_r == OP_POP) || second;

  stack_depth_guard #(
    .DEPTH_W  (DEPTH_W),
    .DEPTH_MAX(DEPTH_MAX)
  ) u_guard (
    .clk  (clk),
    .reset(reset),
    .inc  (state == S_WR),
    .dec  (state == S_INC),
    .clr  (state == S_LOAD),
    .op   (op),
    .depth(depth),
    .ok   (ok)
  );

  // Outputs are registered alongside the state so they describe the state being entered.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_IDLE;
      op_r      <= 3'b000;
      second    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      fault     <= 1'b0;
      sp_outn   <= 1'b1;
      sp_loadn  <= 1'b1;
      sp_cupn   <= 1'b1;
      sp_cdownn <= 1'b1;
      mem_wen   <= 1'b1;
      mem_oen   <= 1'b1;
      byte_sel  <= 1'b0;
      rd_latch  <= 1'b0;
    end else begin
      done      <= 1'b0;
      sp_outn   <= 1'b1;
      sp_loadn  <= 1'b1;
      sp_cupn   <= 1'b1;
      sp_cdownn <= 1'b1;
      mem_wen   <= 1'b1;
      mem_oen   <= 1'b1;
      rd_latch  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req) begin
            op_r   <= op;
            second <= 1'b0;
            busy   <= 1'b1;
            case (op)
              OP_PUSH, OP_CALL: begin
                if (ok) begin
                  state     <= S_DEC;
                  sp_cdownn <= 1'b0;
                  byte_sel  <= (op == OP_CALL);
                end else begin
                  state <= S_ERR;
                  done  <= 1'b1;
                  fault <= 1'b1;
                end
              end
              OP_POP, OP_RET: begin
                if (ok) begin
                  state    <= S_RD;
                  sp_outn  <= 1'b0;
                  mem_oen  <= 1'b0;
                  rd_latch <= 1'b1;
                  byte_sel <= 1'b0;
                end else begin
                  state <= S_ERR;
                  done  <= 1'b1;
                  fault <= 1'b1;
                end
              end
              OP_LOADSP: begin
                state    <= S_LOAD;
                sp_loadn <= 1'b0;
                done     <= 1'b1;
              end
              default: begin
                state <= S_ERR;
                done  <= 1'b1;
                fault <= 1'b1;
              end
            endcase
          end else begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        S_DEC: begin
          state   <= S_WR;
          sp_outn <= 1'b0;
          mem_wen <= 1'b0;
          done    <= last_byte;
        end
        S_WR: begin
          if (last_byte) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            byte_sel <= 1'b0;
          end else begin
            // CALL: high byte written, now the low byte.
            state     <= S_DEC;
            second    <= 1'b1;
            byte_sel  <= 1'b0;
            sp_cdownn <= 1'b0;
          end
        end
        S_RD: begin
          state   <= S_INC;
          sp_cupn <= 1'b0;
          done    <= last_byte;
        end
        S_INC: begin
          if (last_byte) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            byte_sel <= 1'b0;
          end else begin
            // RET: low byte read, now the high byte.
            state    <= S_RD;
            second   <= 1'b1;
            byte_sel <= 1'b1;
            sp_outn  <= 1'b0;
            mem_oen  <= 1'b0;
            rd_latch <= 1'b1;
          end
        end
        S_LOAD, S_ERR: begin
          state    <= S_IDLE;
          busy     <= 1'b0;
          byte_sel <= 1'b0;
        end
        default: begin
          state    <= S_IDLE;
          busy     <= 1'b0;
          byte_sel <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stack_sequencer.sv
// Scoreboard bench for stack_sequencer: expected per-cycle output vectors are queued
// when an operation is issued and compared one per cycle on the falling edge.
module tb_stack_sequencer;

  localparam int DW = 8;
  localparam int DM = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          req = 1'b0;
  logic [2:0]    op = 3'b000;
  logic          busy, done, sp_outn, sp_loadn, sp_cupn, sp_cdownn;
  logic          mem_wen, mem_oen, byte_sel, rd_latch, fault;
  logic [DW-1:0] depth;

  int total = 0;
  int bad = 0;
  logic [10:0] q[$];
  logic        mf = 1'b0;
  int          md = 0;

  stack_sequencer #(.DEPTH_W(DW), .DEPTH_MAX(DM)) dut (
    .clk(clk), .reset(reset), .req(req), .op(op),
    .busy(busy), .done(done), .sp_outn(sp_outn), .sp_loadn(sp_loadn),
    .sp_cupn(sp_cupn), .sp_cdownn(sp_cdownn), .mem_wen(mem_wen), .mem_oen(mem_oen),
    .byte_sel(byte_sel), .rd_latch(rd_latch), .fault(fault), .depth(depth)
  );

  always #5 clk = ~clk;

  // Vector order: busy done outn loadn cupn cdownn wen oen byte_sel rd_latch fault
  function automatic logic [10:0] mk(input logic b, input logic d, input logic o,
                                     input logic l, input logic u, input logic c,
                                     input logic w, input logic e, input logic s,
                                     input logic r);
    return {b, d, o, l, u, c, w, e, s, r, mf};
  endfunction

  task automatic exp_idle();  q.push_back(mk(0,0,1,1,1,1,1,1,0,0)); endtask
  task automatic exp_dec(input logic s); q.push_back(mk(1,0,1,1,1,0,1,1,s,0)); endtask
  task automatic exp_wr(input logic s, input logic d); q.push_back(mk(1,d,0,1,1,1,0,1,s,0)); endtask
  task automatic exp_rd(input logic s); q.push_back(mk(1,0,0,1,1,1,1,0,s,1)); endtask
  task automatic exp_inc(input logic s, input logic d); q.push_back(mk(1,d,1,1,0,1,1,1,s,0)); endtask
  task automatic exp_err();
    mf = 1'b1;
    q.push_back(mk(1,1,1,1,1,1,1,1,0,0));
  endtask

  task automatic check_vec(input string tag);
    logic [10:0] obs;
    logic [10:0] expv;
    obs = {busy, done, sp_outn, sp_loadn, sp_cupn, sp_cdownn, mem_wen, mem_oen,
           byte_sel, rd_latch, fault};
    total++;
    if (q.size() == 0) begin
      bad++;
      $error("FAIL %s scoreboard empty obs=%b", tag, obs);
    end else begin
      expv = q.pop_front();
      assert (obs === expv) else begin
        bad++;
        $error("FAIL %s obs=%b exp=%b", tag, obs, expv);
      end
    end
  endtask

  task automatic check_depth(input string tag);
    logic [DW-1:0] expd;
`ifdef STACK_GUARD_EN
    expd = DW'(md);
`else
    expd = '0;
`endif
    total++;
    assert (depth === expd) else begin
      bad++;
      $error("FAIL %s depth obs=%0d exp=%0d", tag, depth, expd);
    end
  endtask

  // Issue req for one cycle (or hold it with LOADSP while busy) and drain the queue.
  task automatic run(input string tag, input logic [2:0] o, input logic hold);
    @(negedge clk);
    req = 1'b1;
    op  = o;
    while (q.size() > 0) begin
      @(negedge clk);
      check_vec(tag);
      req = (hold && (q.size() > 0)) ? 1'b1 : 1'b0;
      op  = hold ? 3'b100 : 3'b000;
    end
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    mf = 1'b0;
    md = 0;
    exp_idle();
    check_vec(tag);
    check_depth(tag);
  endtask

  initial begin
    do_reset("reset");

    exp_dec(0); exp_wr(0, 1); exp_idle();
    run("push", 3'b000, 1'b0);
    md = 1; check_depth("push_depth");

    exp_rd(0); exp_inc(0, 1); exp_idle();
    run("pop", 3'b001, 1'b0);
    md = 0; check_depth("pop_depth");

    exp_dec(1); exp_wr(1, 0); exp_dec(0); exp_wr(0, 1); exp_idle();
    run("call_busy_req", 3'b010, 1'b1);
    md = 2; check_depth("call_depth");

    exp_rd(0); exp_inc(0, 0); exp_rd(1); exp_inc(1, 1); exp_idle();
    run("ret", 3'b011, 1'b0);
    md = 0; check_depth("ret_depth");

    exp_dec(0); exp_wr(0, 1); exp_idle();
    run("push2", 3'b000, 1'b0);
    md = 1; check_depth("push2_depth");
    q.push_back(mk(1,1,1,0,1,1,1,1,0,0)); exp_idle();
    run("loadsp", 3'b100, 1'b0);
    md = 0; check_depth("loadsp_depth");

`ifdef STACK_GUARD_EN
    exp_err(); exp_idle();
    run("pop_underflow", 3'b001, 1'b0);
    check_depth("underflow_depth");
    do_reset("reset_guard1");
    exp_dec(0); exp_wr(0, 1); exp_idle();
    run("push3", 3'b000, 1'b0);
    md = 1;
    exp_err(); exp_idle();
    run("call_overflow", 3'b010, 1'b0);
    check_depth("overflow_depth");
    do_reset("reset_guard2");
`endif

    exp_err(); exp_idle();
    run("illegal", 3'b111, 1'b0);
    do_reset("reset_clears_fault");

    // CALL aborted by reset during its first WR cycle.
    exp_dec(1); exp_wr(1, 0);
    @(negedge clk);
    req = 1'b1; op = 3'b010;
    @(negedge clk);
    req = 1'b0;
    check_vec("abort_dec");
    @(negedge clk);
    check_vec("abort_wr");
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    mf = 1'b0; md = 0;
    exp_idle();
    check_vec("abort_idle");
    check_depth("abort_depth");
    exp_idle();
    @(negedge clk);
    check_vec("abort_stays_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stack_sequencer.md
STACK_SEQUENCER -- requirements
Module: stack_sequencer

Interface
REQ-001 Parameter: DEPTH_W, default 8, width of the stack depth counter.
REQ-002 Parameter: DEPTH_MAX, default 255, maximum number of bytes held on the stack.
REQ-003 Port: clk  in  1  system clock; all state changes on rising edge.
REQ-004 Port: reset  in  1  synchronous, active-low reset.
REQ-005 Port: req  in  1  operation request, sampled only in IDLE.
REQ-006 Port: op  in  3  000 PUSH, 001 POP, 010 CALL, 011 RET, 100 LOADSP; 101-111 illegal.
REQ-007 Port: busy  out  1  high in every state except IDLE.
REQ-008 Port: done  out  1  one-cycle pulse in the final cycle of an accepted operation.
REQ-009 Port: sp_outn, sp_loadn, sp_cupn, sp_cdownn  out  1 each  active-low stack pointer controls: drive address, load, count up, count down.
REQ-010 Port: mem_wen, mem_oen  out  1 each  active-low memory write strobe and read enable.
REQ-011 Port: byte_sel  out  1  0 = low data byte, 1 = high data byte.
REQ-012 Port: rd_latch  out  1  high for one cycle when memory read data is valid.
REQ-013 Port: fault  out  1  sticky guard error flag.
REQ-014 Port: depth  out  DEPTH_W  current stack depth in bytes.

Function
REQ-015 All active-low controls SHALL be 1 and rd_latch SHALL be 0 outside the states that assert them.
REQ-016 States SHALL be: IDLE, DEC, WR, RD, INC, LOAD, ERR.
REQ-017 IDLE with req=1 SHALL go as follows: PUSH/CALL to DEC; POP/RET to RD; LOADSP to LOAD; illegal op to ERR.
REQ-018 DEC SHALL assert sp_cdownn=0, then go to WR (pre-decrement push).
REQ-019 WR SHALL assert sp_outn=0 and mem_wen=0.
REQ-020 RD SHALL assert sp_outn=0, mem_oen=0 and rd_latch=1, then go to INC (post-increment pop).
REQ-021 INC SHALL assert sp_cupn=0.
REQ-022 LOAD SHALL assert sp_loadn=0 for one cycle, with done=1.
REQ-023 CALL SHALL push the high byte (byte_sel=1) first, then the low byte. RET SHALL pop the low byte (byte_sel=0) first, then the high byte.
REQ-024 Cycle counts: PUSH = 2, POP = 2, CALL = 4, RET = 4, LOADSP = 1, ERR = 1; done SHALL be high in the last cycle; return to IDLE follows.
REQ-025 req while busy=1 SHALL be ignored; op SHALL be captured only at acceptance.
REQ-026 ERR SHALL set fault=1 and pulse done, issuing no SP or memory strobes.
REQ-027 The depth counter SHALL count +1 per byte pushed, -1 per byte popped, and clear on LOADSP.

Reset
REQ-028 reset=0 at a clock edge SHALL force IDLE; busy=0, done=0, fault=0, depth=0; all strobes inactive on the next cycle, including mid-operation.
REQ-029 An operation aborted by reset SHALL NOT be resumed; SP contents are left as-is.

Configuration
REQ-030 The macro STACK_GUARD_EN SHALL gate depth checking.
REQ-031 With STACK_GUARD_EN defined: PUSH/CALL needing more than DEPTH_MAX-depth bytes, or POP/RET needing more than depth bytes, SHALL go to ERR without touching SP.
REQ-032 Without STACK_GUARD_EN: no depth check; depth SHALL be tied to 0; fault SHALL be set only by an illegal op.

Structure
REQ-033 Op encodings and state encodings SHALL live in shared package stack_seq_pkg.
REQ-034 The depth counter and the guard comparison SHALL be sub-module stack_depth_guard; the FSM stays in stack_sequencer.

Verification
REQ-035 Test PUSH from reset: req=1, op=000 -> cycle 1 sp_cdownn=0; cycle 2 sp_outn=0, mem_wen=0, done=1; depth=1.
REQ-036 Test CALL then RET: byte_sel sequence 1,1,0,0 then 0,0,1,1; 4 cycles each; depth 0->2->0; done pulses exactly twice.
REQ-037 Test STACK_GUARD_EN: POP at depth=0 -> ERR, fault=1, no strobes. With DEPTH_MAX=2 and depth=1, CALL -> fault=1.
REQ-038 Test illegal op=111 -> 1-cycle ERR, done=1, fault=1; the following reset=0 clears fault.
REQ-039 Test reset=0 in the WR cycle of a CALL -> next cycle IDLE, busy=0, all strobes 1; a req=1 raised while busy is ignored.
